// File: rtl/flag_control.sv
// flag_control: carries NZCV results of flag-setting instructions through
// MEM and WB stage registers, commits them to the flag register in WB, and
// resolves B.cond in ID using the youngest pending flags.
// Flag vectors are packed as {N, Z, C, V} throughout.
module flag_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic       ex_zero,
    input  logic       ex_overflow,
    input  logic       ex_negative,
    input  logic       ex_carry,
    input  logic       id_bcond,
    input  logic [3:0] id_cond,
    input  logic       reg_zero,
    input  logic       reg_overflow,
    input  logic       reg_negative,
    input  logic       reg_carry,
    output logic       flag_en,
    output logic       flag_zero,
    output logic       flag_overflow,
    output logic       flag_negative,
    output logic       flag_carry,
    output logic       flag_stall,
    output logic       cond_taken
);

    logic       mem_vld;
    logic [3:0] mem_nzcv;
    logic       wb_vld;
    logic [3:0] wb_nzcv;

    logic [3:0] ex_nzcv;
    logic [3:0] reg_nzcv;
    logic [3:0] fwd_nzcv;
    logic       cond_true;

    assign ex_nzcv  = {ex_negative, ex_zero, ex_carry, ex_overflow};
    assign reg_nzcv = {reg_negative, reg_zero, reg_carry, reg_overflow};

    // Pipeline the flag results EX -> MEM -> WB; hold freezes both stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_vld  <= 1'b0;
            mem_nzcv <= 4'b0000;
            wb_vld   <= 1'b0;
            wb_nzcv  <= 4'b0000;
        end else if (!hold) begin
            mem_vld  <= ex_valid & ex_set_flags;
            mem_nzcv <= ex_nzcv;
            wb_vld   <= mem_vld;
            wb_nzcv  <= mem_nzcv;
        end
    end

    // Commit from WB; a held cycle must not write, so the single write
    // happens on the first cycle the pipeline is released.
    assign flag_en       = wb_vld & ~hold;
    assign flag_negative = wb_nzcv[3];
    assign flag_zero     = wb_nzcv[2];
    assign flag_carry    = wb_nzcv[1];
    assign flag_overflow = wb_nzcv[0];

    // A producer still in EX has no flags yet for the branch in ID.
    assign flag_stall = id_bcond & ex_valid & ex_set_flags;

    // Youngest pending flags win; WB beats the register because the
    // register only reflects the WB write on the following cycle.
    always_comb begin
        fwd_nzcv = reg_nzcv;
        if (mem_vld) begin
            fwd_nzcv = mem_nzcv;
        end else if (wb_vld) begin
            fwd_nzcv = wb_nzcv;
        end
    end

    // Evaluate the condition code on the forwarded flags.
    always_comb begin
        logic n, z, c, v;
        n = fwd_nzcv[3];
        z = fwd_nzcv[2];
        c = fwd_nzcv[1];
        v = fwd_nzcv[0];
        cond_true = 1'b1;
        case (id_cond)
            4'd0:    cond_true = z;
            4'd1:    cond_true = ~z;
            4'd2:    cond_true = c;
            4'd3:    cond_true = ~c;
            4'd4:    cond_true = n;
            4'd5:    cond_true = ~n;
            4'd6:    cond_true = v;
            4'd7:    cond_true = ~v;
            4'd8:    cond_true = c & ~z;
            4'd9:    cond_true = ~c | z;
            4'd10:   cond_true = (n == v);
            4'd11:   cond_true = (n != v);
            4'd12:   cond_true = ~z & (n == v);
            4'd13:   cond_true = z | (n != v);
            default: cond_true = 1'b1;
        endcase
    end

    // The decision is only valid when the branch is not being stalled.
    assign cond_taken = cond_true & id_bcond & ~flag_stall;

endmodule
